// File: rtl/ckey_led_toggle.sv
// ckey_led_toggle: debounced key-to-LED controller.
// Each raw key pin is synchronised (two flops), debounced with a per-key
// stability counter, and turned into a debounced level plus a one-cycle
// press pulse. Every accepted press updates a latched LED state.
// Optional feature macro: CKEY_RADIO_EN
//   defined   -> radio-button mode (one lit LED at most, lowest index wins)
//   undefined -> independent per-key toggle
module ckey_led_toggle #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter bit KEY_ACTIVE_LOW  = 1'b1,
    parameter bit LED_ACTIVE_LOW  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS:1]   ckey,
    output logic [1:N_KEYS]   led,
    output logic [N_KEYS:1]   key_level,
    output logic [N_KEYS:1]   key_press
);

    // Pin level that means "not pressed"; synchronisers start here.
    localparam logic [N_KEYS:1] KEY_RELEASED = {N_KEYS{KEY_ACTIVE_LOW}};
    // LED pin level that means "off".
    localparam logic [1:N_KEYS] LED_OFF      = {N_KEYS{LED_ACTIVE_LOW}};
    // Terminal count: the level is accepted on the cycle this value is seen.
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [N_KEYS:1]  s1_q;
    logic [N_KEYS:1]  s2_q;
    logic [N_KEYS:1]  p_s;
    logic [CNT_W-1:0] cnt_q [N_KEYS:1];
    logic [CNT_W-1:0] cnt_d [N_KEYS:1];
    logic [N_KEYS:1]  level_q;
    logic [N_KEYS:1]  level_d;
    logic [N_KEYS:1]  press_q;
    logic [N_KEYS:1]  press_d;
    logic [N_KEYS:1]  st_q;
    logic [N_KEYS:1]  st_d;
    logic [1:N_KEYS]  led_q;

    // Sampled pressed level: 1 = pressed, independent of pin polarity.
    assign p_s = s2_q ^ {N_KEYS{KEY_ACTIVE_LOW}};

    // Two-flop synchroniser for the asynchronous key pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= KEY_RELEASED;
            s2_q <= KEY_RELEASED;
        end else begin
            s1_q <= ckey;
            s2_q <= s1_q;
        end
    end

    // Debounce next state: count consecutive cycles that disagree with the
    // accepted level; accept on the terminal count, restart on any agreement.
    always_comb begin
        level_d = level_q;
        press_d = '0;
        for (int i = 1; i <= N_KEYS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (p_s[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                level_d[i] = p_s[i];
                press_d[i] = p_s[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // LED state next value, driven by the press pulses of this cycle.
    always_comb begin
        st_d = st_q;
`ifdef CKEY_RADIO_EN
        begin : radio_select
            logic found;
            found = 1'b0;
            for (int i = 1; i <= N_KEYS; i++) begin
                if (press_d[i] && !found) begin
                    found = 1'b1;
                    if (st_q[i]) begin
                        st_d = '0;
                    end else begin
                        st_d    = '0;
                        st_d[i] = 1'b1;
                    end
                end else begin
                    found = found;
                end
            end
        end
`else
        st_d = st_q ^ press_d;
`endif
    end

    // Debounce, press pulse, LED state and LED pin registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i <= N_KEYS; i++) begin
                cnt_q[i] <= '0;
            end
            level_q <= '0;
            press_q <= '0;
            st_q    <= '0;
            led_q   <= LED_OFF;
        end else begin
            for (int i = 1; i <= N_KEYS; i++) begin
                cnt_q[i] <= cnt_d[i];
                led_q[i] <= st_d[i] ^ LED_ACTIVE_LOW;
            end
            level_q <= level_d;
            press_q <= press_d;
            st_q    <= st_d;
        end
    end

    assign key_level = level_q;
    assign key_press = press_q;
    assign led       = led_q;

endmodule

// File: tb/tb_ckey_led_toggle.sv
// Bench for ckey_led_toggle (DEBOUNCE_CYCLES=8, both polarities active-low).
// Reference model: pin samples delayed by two edges, then a level is
// accepted when the last DEBOUNCE_CYCLES delayed samples all disagree
// with the current accepted level.
module tb_ckey_led_toggle;

    localparam int NK = 4;
    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK:1]   ckey = 4'b1111;
    logic [1:NK]   led;
    logic [NK:1]   key_level;
    logic [NK:1]   key_press;

    ckey_led_toggle #(
        .N_KEYS          (NK),
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (4),
        .KEY_ACTIVE_LOW  (1'b1),
        .LED_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ckey      (ckey),
        .led       (led),
        .key_level (key_level),
        .key_press (key_press)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int pulses [1:NK];

    // Model state
    logic [NK:1] samp_q [$];
    bit          win_q  [1:NK][$];
    logic [NK:1] m_level;
    logic [NK:1] m_press;
    logic [NK:1] m_st;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        samp_q.delete();
        samp_q.push_back(4'b0000);
        samp_q.push_back(4'b0000);
        for (int k = 1; k <= NK; k++) win_q[k].delete();
        m_level = '0;
        m_press = '0;
        m_st    = '0;
    endtask

    task automatic model_edge();
        logic [NK:1] seen;
        logic [NK:1] rise;
        bit          all_diff;
        int          w;
        if (rst) begin
            model_reset();
        end else begin
            samp_q.push_back(~ckey);
            seen = samp_q.pop_front();
            rise = '0;
            for (int k = 1; k <= NK; k++) begin
                win_q[k].push_back(seen[k]);
                if (win_q[k].size() > DB) void'(win_q[k].pop_front());
                if (win_q[k].size() == DB) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < win_q[k].size(); j++)
                        if (win_q[k][j] == m_level[k]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_level[k] = ~m_level[k];
                        rise[k]    = m_level[k];
                    end
                end
            end
            m_press = rise;
`ifdef CKEY_RADIO_EN
            w = 0;
            for (int k = NK; k >= 1; k--) if (rise[k]) w = k;
            if (w != 0) begin
                if (m_st[w]) m_st = '0;
                else begin
                    m_st    = '0;
                    m_st[w] = 1'b1;
                end
            end
`else
            w = 0;
            m_st = m_st ^ rise;
`endif
        end
    endtask

    function automatic logic [1:NK] exp_led();
        logic [1:NK] r;
        for (int k = 1; k <= NK; k++) r[k] = ~m_st[k];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        for (int k = 1; k <= NK; k++) if (key_press[k]) pulses[k]++;
        check_val("level", 32'(key_level), 32'(m_level));
        check_val("press", 32'(key_press), 32'(m_press));
        check_val("led",   32'(led),       32'(exp_led()));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_press(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (key_press == '0 && n < 30);
    endtask

    task automatic clear_pulses();
        for (int k = 1; k <= NK; k++) pulses[k] = 0;
    endtask

    task automatic do_reset();
        ckey = 4'b1111;
        rst  = 1'b1;
        run(2);
        rst  = 1'b0;
    endtask

    int n;
    int slow;

    initial begin
        model_reset();
        clear_pulses();

        // 1: reset with all keys held, then release reset
        ckey = 4'b0000;
        rst  = 1'b1;
        run(2);
        check_val("t1_rst_led", 32'(led), 32'(4'b1111));
        check_val("t1_rst_lvl", 32'(key_level), 32'(4'b0000));
        rst = 1'b0;
        wait_press(n);
        check_val("t1_lat", 32'(n), 32'(10));
        check_val("t1_press", 32'(key_press), 32'(4'b1111));
        check_val("t1_led", 32'(led), 32'(4'b0000));
        step();
        check_val("t1_one_cycle", 32'(key_press), 32'(4'b0000));
        ckey = 4'b1111;
        run(15);
        do_reset();

        // 2: clean press, release, second press on key 2
        clear_pulses();
        ckey = 4'b1101;
        wait_press(n);
        check_val("t2_lat", 32'(n), 32'(10));
        check_val("t2_press", 32'(key_press), 32'(4'b0010));
        check_val("t2_led", 32'(led), 32'(4'b1011));
        run(10);
        ckey = 4'b1111;
        run(20);
        check_val("t2_rel_pulses", 32'(pulses[2]), 32'(1));
        check_val("t2_rel_led", 32'(led), 32'(4'b1011));
        ckey = 4'b1101;
        run(20);
        check_val("t2_led2", 32'(led), 32'(4'b1111));
        ckey = 4'b1111;
        run(15);
        do_reset();

        // 3: bounce rejected, then a clean 12-cycle press accepted
        clear_pulses();
        ckey = 4'b1110; run(5);
        ckey = 4'b1111; run(1);
        ckey = 4'b1110; run(7);
        ckey = 4'b1111; run(15);
        check_val("t3_bounce_pulses", 32'(pulses[1]), 32'(0));
        check_val("t3_bounce_led", 32'(led), 32'(4'b1111));
        ckey = 4'b1110; run(12);
        ckey = 4'b1111; run(15);
        check_val("t3_pulses", 32'(pulses[1]), 32'(1));
        check_val("t3_led", 32'(led), 32'(4'b0111));
        do_reset();

        // 4: simultaneous press of keys 3 and 4, long hold
        clear_pulses();
        ckey = 4'b0011;
        wait_press(n);
        check_val("t4_lat", 32'(n), 32'(10));
        check_val("t4_press", 32'(key_press), 32'(4'b1100));
        run(999);
        check_val("t4_pulses3", 32'(pulses[3]), 32'(1));
        check_val("t4_pulses4", 32'(pulses[4]), 32'(1));
        check_val("t4_led", 32'(led), 32'(4'b1100));
        ckey = 4'b1111;
        run(15);
        do_reset();

        // 5: reset mid-debounce with the key still held
        ckey = 4'b1110;
        run(5);
        rst = 1'b1;
        #1;
        check_val("t5_async_led", 32'(led), 32'(4'b1111));
        check_val("t5_async_press", 32'(key_press), 32'(4'b0000));
        step();
        rst = 1'b0;
        wait_press(n);
        check_val("t5_lat", 32'(n), 32'(10));
        check_val("t5_press", 32'(key_press), 32'(4'b0001));
        ckey = 4'b1111;
        run(15);

`ifdef CKEY_RADIO_EN
        // 6: radio-button mode
        do_reset();
        ckey = 4'b1110; run(12); ckey = 4'b1111; run(12);
        check_val("t6_k1", 32'(led), 32'(4'b0111));
        ckey = 4'b1011; run(12); ckey = 4'b1111; run(12);
        check_val("t6_k3", 32'(led), 32'(4'b1101));
        ckey = 4'b1011; run(12); ckey = 4'b1111; run(12);
        check_val("t6_k3_off", 32'(led), 32'(4'b1111));
        ckey = 4'b0101; run(12); ckey = 4'b1111; run(12);
        check_val("t6_k24", 32'(led), 32'(4'b1011));
`endif

        // Random phase: alternating bouncy and calm segments, rare resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            slow = ((i / 200) % 2 == 1) ? 20 : 4;
            for (int k = 1; k <= NK; k++)
                if ($urandom_range(slow - 1, 0) == 0) ckey[k] = ~ckey[k];
            rst = ($urandom_range(399, 0) == 0) ? 1'b1 : 1'b0;
            step();
        end
        rst = 1'b0;
        run(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ckey_led_toggle.md
Name: ckey_led_toggle

Overview:
Debounced key-to-LED controller: the registered counterpart of the direct key-to-LED wiring path.
- Samples the raw mechanical `ckey` inputs, synchronises and debounces each one, and detects press events.
- Each press toggles a latched LED state, so LEDs hold their value after the key is released.
- Sits at the board I/O boundary: `ckey` pins in, `led` pins out, press pulses available to other logic.

Parameters:
N_KEYS, 4, number of keys and LEDs (`ckey[N_KEYS:1]`, `led[1:N_KEYS]`)
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a level change (20 ms at 50 MHz); must be >= 2
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES
KEY_ACTIVE_LOW, 1, 1: pin low = pressed; 0: pin high = pressed
LED_ACTIVE_LOW, 1, 1: drive pin low to light LED; 0: drive high

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  asynchronous, active-high reset
ckey  input  N_KEYS  raw key pins `[N_KEYS:1]`, asynchronous to clk
led  output  N_KEYS  LED pins `[1:N_KEYS]`; `led[i]` belongs to `ckey[i]`
key_level  output  N_KEYS  debounced pressed level per key, 1 = pressed
key_press  output  N_KEYS  one-cycle pulse per accepted press

Behaviour:
- Reset (async, rst=1):
  - sync flops = released pin level;
  - debounce counters = 0;
  - key_level = 0, key_press = 0;
  - toggle state st = 0, so led = all off (all 1s when LED_ACTIVE_LOW=1).
- Synchroniser: two flops per key, s1<=ckey, s2<=s1. Sampled pressed level p[i] = s2[i] XOR KEY_ACTIVE_LOW.
- Debounce, per key, independent:
  - if p==key_level: cnt<=0;
  - else if cnt==DEBOUNCE_CYCLES-1: key_level<=p, cnt<=0;
  - else: cnt<=cnt+1.
- Latency:
  - key_level changes exactly 2+DEBOUNCE_CYCLES clk edges after a clean pin transition (pin change set up before edge 0).
  - Any bounce that restores p==key_level before the count completes resets cnt to 0; no output change.
- key_press[i]:
  - registered; asserted in the cycle key_level[i] goes 0->1, for exactly 1 cycle;
  - no pulse on release.
- Toggle: on key_press[i], st[i] <= ~st[i] (same edge that raises key_press). Release leaves st unchanged.
- LED drive: led[i] = st[i] XOR LED_ACTIVE_LOW. Purely registered path, no combinational path from ckey.
- Boundaries:
  - Simultaneous presses on several keys: each toggles independently in the same cycle.
  - Key held indefinitely: a single press, no repeat.
  - cnt never exceeds DEBOUNCE_CYCLES-1; no wrap.
  - rst asserted mid-debounce or mid-press: all state cleared immediately.
  - A key held through rst deassertion is accepted as a new press after 2+DEBOUNCE_CYCLES cycles.

Optional Feature:
Macro: CKEY_RADIO_EN
- Defined: radio-button mode. A press on key i sets st = one-hot bit i, and all other LEDs turn off.
  - Pressing the already-lit key turns all LEDs off.
  - Multiple presses in the same cycle: the lowest index wins.
- Undefined: independent per-key toggle as above.
- key_level and key_press behave identically in both modes.

Test Plan (DEBOUNCE_CYCLES=8, CNT_W=4, both ACTIVE_LOW=1):
1. Reset: rst=1 with ckey=4'b0000 (all pressed) -> led=4'b1111, key_level=0, key_press=0. After rst=0, all four pulse once at cycle 10 and led=4'b0000.
2. Clean press: ckey[2] 1->0 held 20 cycles -> key_level[2]=1 and a 1-cycle key_press[2] exactly 10 cycles later; led[2]=0. Release -> led[2] stays 0, no pulse. Second press -> led[2]=1.
3. Bounce: ckey[1] low for 5 cycles, high 1 cycle, low for 7 cycles, then high -> no key_press, led=4'b1111. Then a 12-cycle low -> exactly one pulse.
4. Simultaneous: ckey[3] and ckey[4] pressed on the same edge -> both pulse in the same cycle, led=4'b1100. Hold 1000 cycles -> no further pulses.
5. Reset mid-debounce: ckey[1] low for 5 cycles, then rst pulse -> led=4'b1111 and counters clear. Key still held -> press accepted 10 cycles after rst falls.
6. With CKEY_RADIO_EN: press 1, then 3 -> led 4'b0111, then 4'b1101. Press 3 again -> 4'b1111. Press 2+4 together -> 4'b1011.
